stage_sequencer: RTL and testbench

Synchronous control FSM that sequences the 5-bit-PC processor datapath through fetch, decode, execute and write-back. It replaces the delay-scheduled per-stage flags with one clocked state machine. It drives the program ROM address, the instruction register, register-file read/write strobes and the ALU operand-load strobe. It also owns the PC, halt detection and a retired-instruction counter.

---
 rtl/stage_sequencer.sv | 96 +++++++++
 tb/tb_stage_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Clocked fetch/decode/execute/write-back sequencer for the 5-bit-PC datapath.
// Owns the PC, instruction register, halt detection and the retired-instruction counter.
module stage_sequencer #(
  parameter int         PC_W        = 5,
  parameter logic [4:0] HALT_OPCODE = 5'b11111,
  parameter int         RET_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic             stall,
  output logic [PC_W-1:0]  prog_addr,
  input  logic [31:0]      prog_data,
  output logic [31:0]      ir,
  output logic [4:0]       opcode,
  output logic [4:0]       rdst,
  output logic [4:0]       rsrc1,
  output logic [4:0]       rsrc2,
  output logic             rf_rd,
  output logic             alu_load,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       state,
  output logic             busy,
  output logic             halted,
  output logic [RET_W-1:0] retired
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // FETCH   | ROM addressed by pc, ir loads at the edge
  // DECODE  | register file read, halt opcode check
  // EXECUTE | ALU operates, held by stall
  // WRITE   | result written back, pc and retired advance
  // HALTED  | halt opcode seen, waiting for start
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_HALTED  = 3'd5;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      retired  <= '0;
      alu_load <= 1'b0;
    end else begin
      alu_load <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= start_pc;
          end
        end
        S_FETCH: begin
          ir    <= prog_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (ir[31:27] == HALT_OPCODE) begin
            state <= S_HALTED;
          end else begin
            state    <= S_EXECUTE;
            // registered strobe so it covers only the first EXECUTE cycle
            alu_load <= 1'b1;
          end
        end
        S_EXECUTE: begin
          if (!stall) state <= S_WRITE;
        end
        S_WRITE: begin
          pc    <= pc + 1'b1;
          state <= S_FETCH;
          if (retired != '1) retired <= retired + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign prog_addr = pc;
  assign opcode    = ir[31:27];
  assign rdst      = ir[26:22];
  assign rsrc1     = ir[4:0];
  assign rsrc2     = ir[9:5];
  assign rf_rd     = (state == S_DECODE) || (state == S_EXECUTE);
  assign rf_we     = (state == S_WRITE);
  assign busy      = (state >= S_FETCH) && (state <= S_WRITE);
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer against an instruction-level schedule model:
// each instruction's cycle-by-cycle phases are predicted from its stall count.
module tb_stage_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  start_pc;
  logic        stall;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] ir;
  logic [4:0]  opcode, rdst, rsrc1, rsrc2;
  logic        rf_rd, alu_load, rf_we, busy, halted;
  logic [4:0]  pc;
  logic [2:0]  state;
  logic [7:0]  retired;

  logic [31:0] rom [32];
  assign prog_data = rom[prog_addr];

  stage_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .start_pc(start_pc), .stall(stall),
    .prog_addr(prog_addr), .prog_data(prog_data), .ir(ir), .opcode(opcode),
    .rdst(rdst), .rsrc1(rsrc1), .rsrc2(rsrc2), .rf_rd(rf_rd), .alu_load(alu_load),
    .rf_we(rf_we), .pc(pc), .state(state), .busy(busy), .halted(halted),
    .retired(retired)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // model: architectural pc, retired count and instruction register
  int          m_pc;
  int          m_ret;
  logic [31:0] m_ir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] w;
    w = $urandom;
    w[31:27] = 5'($urandom_range(0, 30));
    return w;
  endfunction

  task automatic check_outputs(input int st, input bit al);
    check("state",     32'(state),     32'(st));
    check("pc",        32'(pc),        32'(m_pc));
    check("prog_addr", 32'(prog_addr), 32'(m_pc));
    check("ir",        ir,             m_ir);
    check("opcode",    32'(opcode),    32'(m_ir[31:27]));
    check("rdst",      32'(rdst),      32'(m_ir[26:22]));
    check("rsrc1",     32'(rsrc1),     32'(m_ir[4:0]));
    check("rsrc2",     32'(rsrc2),     32'(m_ir[9:5]));
    check("rf_rd",     32'(rf_rd),     32'(st == 2 || st == 3));
    check("alu_load",  32'(alu_load),  32'(al));
    check("rf_we",     32'(rf_we),     32'(st == 4));
    check("busy",      32'(busy),      32'(st >= 1 && st <= 4));
    check("halted",    32'(halted),    32'(st == 5));
    check("retired",   32'(retired),   32'(m_ret));
  endtask

  // n cycles parked in IDLE (0) or HALTED (5) with start low
  task automatic park(input int n, input int st);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_outputs(st, 1'b0);
      start    = 1'b0;
      start_pc = 5'($urandom);
      stall    = 1'($urandom);
    end
  endtask

  // called right after park(): start is sampled at the next edge
  task automatic begin_run(input int p);
    start    = 1'b1;
    start_pc = 5'(p);
    m_pc     = p;
  endtask

  // One instruction from FETCH; k stall cycles in EXECUTE. abort_at >= 0 asserts
  // reset (with start and stall high) at the end of that cycle of the instruction.
  task automatic run_instr(input int k, input int abort_at, output bit was_halt);
    logic [31:0] w;
    int          ncyc;
    int          st;
    w        = rom[m_pc];
    was_halt = (w[31:27] == 5'b11111);
    ncyc     = was_halt ? 2 : 4 + k;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (c == 0)             st = 1;
      else if (c == 1)        st = 2;
      else if (c == ncyc - 1) st = 4;
      else                    st = 3;
      check_outputs(st, !was_halt && c == 2);
      if (c == abort_at) begin
        reset = 1'b1;
        start = 1'b1;
        stall = 1'b1;
        return;
      end
      if (c >= 2 && c < 2 + k)       stall = 1'b1;
      else if (c < 2 || c == ncyc-1) stall = 1'($urandom);
      else                           stall = 1'b0;
      start    = 1'($urandom);
      start_pc = 5'($urandom);
      if (c == 0) m_ir = w;
    end
    if (!was_halt) begin
      m_pc  = (m_pc + 1) % 32;
      m_ret = (m_ret < 255) ? m_ret + 1 : 255;
    end
  endtask

  task automatic reset_check();
    @(negedge clock);
    m_pc  = 0;
    m_ret = 0;
    m_ir  = '0;
    check_outputs(0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    for (int i = 0; i < 32; i++) rom[i] = rnd_op();
    rom[3] = {5'b11111, 27'b0};
    rom[9] = {5'b11111, 27'h155_aa55};

    reset = 1'b1; start = 1'b1; stall = 1'b1; start_pc = 5'd9;
    @(posedge clock);
    reset_check();
    park(3, 0);

    // three ordinary ops then halt at 3
    begin_run(0);
    for (int i = 0; i < 3; i++) run_instr(0, -1, h);
    run_instr(0, -1, h);
    check("halt_seen", 32'(h), 32'd1);
    park(3, 5);
    check("halt_ret", 32'(retired), 32'd3);

    // restart from HALTED at 7, stalled op then random, halt at 9
    begin_run(7);
    run_instr(3, -1, h);
    run_instr($urandom_range(0, 3), -1, h);
    run_instr(0, -1, h);
    park(2, 5);

    // wrap from 31 to 0, through to the halt at 3
    begin_run(31);
    for (int i = 0; i < 5; i++) run_instr($urandom_range(0, 2), -1, h);
    park(2, 5);

    // reset mid-EXECUTE while stalled, then coincident with WRITE
    begin_run(10);
    run_instr(2, 3, h);
    reset_check();
    park(2, 0);
    begin_run(10);
    run_instr(0, 3, h);
    reset_check();
    park(2, 0);

    // long run for retired saturation
    rom[3] = rnd_op();
    rom[9] = rnd_op();
    begin_run($urandom_range(0, 31));
    for (int i = 0; i < 300; i++) run_instr($urandom_range(0, 2), -1, h);
    @(negedge clock);
    check("ret_sat", 32'(retired), 32'd255);
    reset = 1'b1;
    reset_check();
    park(2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
